// File: rtl/and4_sweep_ctrl.sv
// and4_sweep_ctrl: self-test sequencer for a 4-input AND gate.
// Drives all 16 input vectors in ascending order. After each vector has been
// driven for a settle time, the sequencer samples the gate output and compares
// it with a&b&c&d. It reports pass/fail, the mismatch count and the first
// failing vector.
module and4_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       f_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic [3:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] mismatch_cnt,
   output logic [3:0] first_fail_idx,
   output logic       first_fail_vld
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Last settle count value before moving to SAMPLE (unused when no settle time)
   localparam logic [CNT_W-1:0] SETTLE_LAST =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] settle_cnt;

   logic       expected;
   logic       miss;
   logic [4:0] cnt_next;

   // The gate inputs are the vector index bits. vec_idx is held at 0 in IDLE
   // and at 15 in DONE, so a..d follow from the same register.
   assign a = vec_idx[3];
   assign b = vec_idx[2];
   assign c = vec_idx[1];
   assign d = vec_idx[0];

   // Compare result and the saturating mismatch count used in SAMPLE
   always_comb begin
      expected = (vec_idx == 4'hF);
      miss     = (f_in != expected);
      cnt_next = mismatch_cnt;
      if (miss && (mismatch_cnt != 5'd16)) begin
         cnt_next = mismatch_cnt + 5'd1;
      end
   end

   // Sweep sequencer. All outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         vec_idx        <= 4'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         mismatch_cnt   <= 5'd0;
         first_fail_idx <= 4'd0;
         first_fail_vld <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  vec_idx        <= 4'd0;
                  mismatch_cnt   <= 5'd0;
                  first_fail_vld <= 1'b0;
                  first_fail_idx <= 4'd0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  state          <= DRIVE;
               end
            end
            DRIVE: begin
               if (abort) begin
                  state   <= IDLE;
                  vec_idx <= 4'd0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
               end else begin
                  settle_cnt <= '0;
                  state      <= (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state   <= IDLE;
                  vec_idx <= 4'd0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt + CNT_ONE;
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= SAMPLE;
                  end
               end
            end
            SAMPLE: begin
               if (abort) begin
                  // abort takes priority: this vector's compare is discarded
                  state   <= IDLE;
                  vec_idx <= 4'd0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
               end else begin
                  mismatch_cnt <= cnt_next;
                  if (miss && !first_fail_vld) begin
                     first_fail_idx <= vec_idx;
                     first_fail_vld <= 1'b1;
                  end
                  if (vec_idx == 4'hF) begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= (cnt_next == 5'd0);
                     busy  <= 1'b0;
                  end else begin
                     vec_idx <= vec_idx + 4'd1;
                     state   <= DRIVE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               vec_idx <= 4'd0;
               busy    <= 1'b0;
               done    <= 1'b0;
               pass    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_and4_sweep_ctrl.sv
// Testbench for and4_sweep_ctrl: directed scenarios on a SETTLE_CYCLES=2 instance
// and a SETTLE_CYCLES=0 instance. A gate model can be good, stuck-at-0 or stuck-at-1.
module tb_and4_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // gate model: 0 = good AND, 1 = stuck-at-0, 2 = stuck-at-1
   int mode;

   // slow instance (SETTLE_CYCLES = 2)
   logic       start_s, abort_s, f_s;
   logic       a_s, b_s, c_s, d_s;
   logic [3:0] vec_s;
   logic       busy_s, done_s, pass_s;
   logic [4:0] mcnt_s;
   logic [3:0] ffidx_s;
   logic       ffvld_s;

   // fast instance (SETTLE_CYCLES = 0)
   logic       start_f, abort_f, f_f;
   logic       a_f, b_f, c_f, d_f;
   logic [3:0] vec_f;
   logic       busy_f, done_f, pass_f;
   logic [4:0] mcnt_f;
   logic [3:0] ffidx_f;
   logic       ffvld_f;

   assign f_s = (mode == 0) ? (a_s & b_s & c_s & d_s) : (mode == 2);
   assign f_f = (mode == 0) ? (a_f & b_f & c_f & d_f) : (mode == 2);

   and4_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .f_in(f_s),
      .a(a_s), .b(b_s), .c(c_s), .d(d_s), .vec_idx(vec_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .mismatch_cnt(mcnt_s),
      .first_fail_idx(ffidx_s), .first_fail_vld(ffvld_s)
   );

   and4_sweep_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f), .f_in(f_f),
      .a(a_f), .b(b_f), .c(c_f), .d(d_f), .vec_idx(vec_f),
      .busy(busy_f), .done(done_f), .pass(pass_f), .mismatch_cnt(mcnt_f),
      .first_fail_idx(ffidx_f), .first_fail_vld(ffvld_f)
   );

   // observation mux selecting which instance the sweep task watches
   bit         sel;
   logic [3:0] m_vec, m_abcd;
   logic       m_busy, m_done;
   always_comb begin
      m_vec  = sel ? vec_f  : vec_s;
      m_abcd = sel ? {a_f, b_f, c_f, d_f} : {a_s, b_s, c_s, d_s};
      m_busy = sel ? busy_f : busy_s;
      m_done = sel ? done_f : done_s;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pulse start on the slow instance; returns 1 time unit after DRIVE entry
   task automatic do_start();
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
   endtask

   // follow a sweep from DRIVE entry until done rises (bounded)
   task automatic sweep(input string tag, input int per);
      int k;
      int errs;
      k = 0;
      errs = 0;
      while (!m_done && k < 200) begin
         if (m_vec != 4'(k / per) || m_abcd != m_vec || !m_busy) errs++;
         tick();
         k++;
      end
      check({tag, "_len"}, k, 16 * per);
      check({tag, "_seq"}, errs, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start_s = 1'b0; abort_s = 1'b0;
      start_f = 1'b0; abort_f = 1'b0;
      mode = 0;
      sel = 1'b0;
      #12;
      // reset values
      check("rst_busy", busy_s, 0);
      check("rst_done", done_s, 0);
      check("rst_pass", pass_s, 0);
      check("rst_mcnt", mcnt_s, 0);
      check("rst_ffvld", ffvld_s, 0);
      check("rst_ffidx", ffidx_s, 0);
      check("rst_vec", vec_s, 0);
      check("rst_abcd", {a_s, b_s, c_s, d_s}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // good gate
      mode = 0;
      do_start();
      check("good_busy", busy_s, 1);
      sweep("good", 4);
      check("good_pass", pass_s, 1);
      check("good_mcnt", mcnt_s, 0);
      check("good_ffvld", ffvld_s, 0);
      check("good_busy_end", busy_s, 0);
      check("good_abcd_done", {a_s, b_s, c_s, d_s}, 15);

      // stuck-at-0: only vector 15 mismatches
      mode = 1;
      do_start();
      sweep("s0", 4);
      check("s0_pass", pass_s, 0);
      check("s0_mcnt", mcnt_s, 1);
      check("s0_ffidx", ffidx_s, 15);
      check("s0_ffvld", ffvld_s, 1);
      // abort while in DONE is ignored
      abort_s = 1'b1;
      tick();
      abort_s = 1'b0;
      check("done_abort_ign", done_s, 1);

      // stuck-at-1, launched with start and abort together (start wins)
      mode = 2;
      start_s = 1'b1; abort_s = 1'b1;
      tick();
      start_s = 1'b0; abort_s = 1'b0;
      check("sa_busy", busy_s, 1);
      check("sa_mcnt_clr", mcnt_s, 0);
      check("sa_ffvld_clr", ffvld_s, 0);
      sweep("s1", 4);
      check("s1_pass", pass_s, 0);
      check("s1_mcnt", mcnt_s, 15);
      check("s1_ffidx", ffidx_s, 0);
      // rerun with a good gate: results cleared
      mode = 0;
      do_start();
      check("rerun_mcnt_clr", mcnt_s, 0);
      check("rerun_ffvld_clr", ffvld_s, 0);
      sweep("rerun", 4);
      check("rerun_pass", pass_s, 1);
      check("rerun_mcnt", mcnt_s, 0);

      // abort in SETTLE of vector 5 (offset 21 from DRIVE entry)
      mode = 2;
      do_start();
      repeat (21) tick();
      check("ab_vec_before", vec_s, 5);
      abort_s = 1'b1;
      tick();
      abort_s = 1'b0;
      check("ab_abcd", {a_s, b_s, c_s, d_s}, 0);
      check("ab_vec", vec_s, 0);
      check("ab_done", done_s, 0);
      check("ab_busy", busy_s, 0);
      check("ab_mcnt_kept", mcnt_s, 5);
      check("ab_ffvld_kept", ffvld_s, 1);
      tick();
      check("ab_stays_idle", busy_s, 0);
      mode = 0;
      do_start();
      check("ab_restart_busy", busy_s, 1);
      check("ab_restart_mcnt", mcnt_s, 0);
      sweep("ab_restart", 4);
      check("ab_restart_pass", pass_s, 1);

      // SETTLE_CYCLES=0 with start held high throughout the sweep
      sel = 1'b1;
      mode = 0;
      start_f = 1'b1;
      tick();
      check("fast_busy", busy_f, 1);
      sweep("fast", 2);
      start_f = 1'b0;
      check("fast_pass", pass_f, 1);
      check("fast_mcnt", mcnt_f, 0);

      // asynchronous reset mid-sweep (stuck-at-1: 7 mismatches by offset 30)
      sel = 1'b0;
      mode = 2;
      do_start();
      repeat (30) tick();
      check("rm_mcnt_before", mcnt_s, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check("rm_busy", busy_s, 0);
      check("rm_vec", vec_s, 0);
      check("rm_abcd", {a_s, b_s, c_s, d_s}, 0);
      check("rm_mcnt", mcnt_s, 0);
      check("rm_ffvld", ffvld_s, 0);
      check("rm_ffidx", ffidx_s, 0);
      check("rm_done", done_s, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rm_idle_after", busy_s, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
